// File: rtl/if_id_stage_if.sv
// IF/ID stage bundle: fetch-side inputs, EX hazard/branch feedback, and
// the registered decode-side outputs plus PC/bubble control and counters.
// slave = the pipeline register itself; master = whoever drives and observes it.
interface if_id_stage_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_if;
  logic [63:0]      pc_if;
  logic             valid_if;
  logic             ab_sel_id;
  logic             MemtoReg_ex;
  logic             RegWrite_ex;
  logic [4:0]       Rd_ex;
  logic             BrTaken;

  logic [31:0]      instr_id;
  logic [63:0]      pc_id;
  logic             valid_id;
  logic             pc_write;
  logic             bubble_id;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  instr_if, pc_if, valid_if, ab_sel_id,
    input  MemtoReg_ex, RegWrite_ex, Rd_ex, BrTaken,
    output instr_id, pc_id, valid_id, pc_write, bubble_id,
    output state, stall_cnt, flush_cnt
  );

  modport master (
    output instr_if, pc_if, valid_if, ab_sel_id,
    output MemtoReg_ex, RegWrite_ex, Rd_ex, BrTaken,
    input  instr_id, pc_id, valid_id, pc_write, bubble_id,
    input  state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall and branch flush (RUN/STALL/FLUSH FSM).
// Latency: one cycle instr_if -> instr_id; a load-use hazard inserts exactly one bubble.
// Backpressure: pc_write=0 holds the PC during a stall; optional IF_ID_PERF_CNT_EN adds counters.
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'hD503201F,
  parameter int          CNT_W     = 32
) (
  input logic          clk,
  input logic          reset,
  if_id_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] instr_q, instr_n;
  logic [63:0] pc_q, pc_n;
  logic        valid_q, valid_n;
  logic        enter_stall, enter_flush;
  logic        hazard;
  logic [4:0]  rn_id, ab_id;

  // Source registers of the instruction sitting in decode
  assign rn_id = instr_q[9:5];
  assign ab_id = bus.ab_sel_id ? instr_q[4:0] : instr_q[20:16];

  // Load-use hazard; only RUN can stall, so a stall never repeats back to back
  assign hazard = (state_q == ST_RUN) & valid_q & bus.MemtoReg_ex & bus.RegWrite_ex &
                  (bus.Rd_ex != 5'd31) & ((bus.Rd_ex == rn_id) | (bus.Rd_ex == ab_id));

  // Next-state and IF/ID contents; a taken branch beats the hazard
  always_comb begin
    state_n     = ST_RUN;
    instr_n     = bus.instr_if;
    pc_n        = bus.pc_if;
    valid_n     = bus.valid_if;
    enter_stall = 1'b0;
    enter_flush = 1'b0;
    if (state_q == ST_BAD) begin
      // Illegal encoding recovers to RUN with the slot scrubbed
      instr_n = NOP_INSTR;
      pc_n    = 64'd0;
      valid_n = 1'b0;
    end else if (bus.BrTaken) begin
      state_n     = ST_FLUSH;
      instr_n     = NOP_INSTR;
      pc_n        = 64'd0;
      valid_n     = 1'b0;
      enter_flush = 1'b1;
    end else if (hazard) begin
      state_n     = ST_STALL;
      instr_n     = instr_q;
      pc_n        = pc_q;
      valid_n     = valid_q;
      enter_stall = 1'b1;
    end
  end

  // State and pipeline register update with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      instr_q <= NOP_INSTR;
      pc_q    <= 64'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      instr_q <= instr_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
    end
  end

  // PC may always advance under reset; otherwise hold only on an unbranched hazard
  assign bus.pc_write  = ~reset | ~hazard | bus.BrTaken;
  assign bus.bubble_id = reset & hazard & ~bus.BrTaken;

  assign bus.instr_id = instr_q;
  assign bus.pc_id    = pc_q;
  assign bus.valid_id = valid_q;
  assign bus.state    = state_q;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating event counters for stall entries and flush entries
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (enter_stall && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (enter_flush && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  logic unused_cnt;
  assign unused_cnt    = enter_stall ^ enter_flush;
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-level reference model.
module tb_if_id_stage;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam logic [31:0] ADD   = 32'h8B040065;  // ADD X5,X3,X4
  localparam logic [31:0] RN31  = 32'h8B0403E5;  // Rn=31, Rm=4
  localparam logic [31:0] STUR  = 32'hF8000047;  // STUR X7,[X2]
  localparam logic [31:0] NEXT  = 32'h11111111;
`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_id_stage_if #(.CNT_W(CNT_W)) bus ();
  if_id_stage #(.NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: what each slot must hold ----------------
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic        m_valid;
  logic [1:0]  m_state;
  int          m_stalls, m_flushes;
  bit          m_live = 1'b0;

  function automatic logic load_use();
    logic [4:0] src2;
    src2 = bus.ab_sel_id ? m_instr[4:0] : m_instr[20:16];
    return reset && (m_state == 2'b00) && m_valid && bus.MemtoReg_ex && bus.RegWrite_ex &&
           (bus.Rd_ex != 5'd31) && (bus.Rd_ex == m_instr[9:5] || bus.Rd_ex == src2);
  endfunction

  function automatic logic [CNT_W-1:0] expect_cnt(input int events);
    if (!PERF) return '0;
    if (events >= (1 << CNT_W) - 1) return '1;
    return CNT_W'(events);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_instr <= NOP; m_pc <= 64'd0; m_valid <= 1'b0; m_state <= 2'b00;
      m_stalls <= 0; m_flushes <= 0; m_live <= 1'b1;
    end else if (bus.BrTaken) begin
      m_instr <= NOP; m_pc <= 64'd0; m_valid <= 1'b0; m_state <= 2'b10;
      m_flushes <= m_flushes + 1;
    end else if (load_use()) begin
      m_state <= 2'b01;
      m_stalls <= m_stalls + 1;
    end else begin
      m_instr <= bus.instr_if; m_pc <= bus.pc_if; m_valid <= bus.valid_if; m_state <= 2'b00;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("instr_id", 64'(bus.instr_id), 64'(m_instr));
      chk("pc_id", bus.pc_id, m_pc);
      chk("valid_id", 64'(bus.valid_id), 64'(m_valid));
      chk("state", 64'(bus.state), 64'(m_state));
      chk("pc_write", 64'(bus.pc_write), 64'(!load_use() || bus.BrTaken));
      chk("bubble_id", 64'(bus.bubble_id), 64'(load_use() && !bus.BrTaken));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(expect_cnt(m_stalls)));
      chk("flush_cnt", 64'(bus.flush_cnt), 64'(expect_cnt(m_flushes)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[4:0]   = pick_reg();
    w[9:5]   = pick_reg();
    w[20:16] = pick_reg();
    return w;
  endfunction

  initial begin
    bus.instr_if = 32'd0; bus.pc_if = 64'd0; bus.valid_if = 1'b0; bus.ab_sel_id = 1'b0;
    bus.MemtoReg_ex = 1'b0; bus.RegWrite_ex = 1'b0; bus.Rd_ex = 5'd0; bus.BrTaken = 1'b1;
    reset = 1'b0;

    // Reset overrides a pending branch
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", 64'(bus.instr_id), 64'(32'hD503201F));
    chk("rst_valid", 64'(bus.valid_id), 64'd0);
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(bus.flush_cnt), 64'd0);
    chk("rst_pc_write", 64'(bus.pc_write), 64'd1);
    chk("rst_bubble", 64'(bus.bubble_id), 64'd0);

    // Load-use: LDUR X3 in EX, ADD X5,X3,X4 in ID
    tick(); reset = 1'b1; bus.BrTaken = 1'b0; bus.instr_if = ADD; bus.pc_if = 64'h1000; bus.valid_if = 1'b1;
    tick(); bus.MemtoReg_ex = 1'b1; bus.RegWrite_ex = 1'b1; bus.Rd_ex = 5'd3;
    bus.instr_if = NEXT; bus.pc_if = 64'h1004;
    @(negedge clk);
    chk("lu_instr", 64'(bus.instr_id), 64'(ADD));
    chk("lu_pc_write", 64'(bus.pc_write), 64'd0);
    chk("lu_bubble", 64'(bus.bubble_id), 64'd1);
    tick(); bus.MemtoReg_ex = 1'b0; bus.RegWrite_ex = 1'b0;
    @(negedge clk);
    chk("lu_stall_state", 64'(bus.state), 64'd1);
    chk("lu_hold_instr", 64'(bus.instr_id), 64'(ADD));
    chk("lu_stall_pc_write", 64'(bus.pc_write), 64'd1);
    tick();
    @(negedge clk);
    chk("lu_back_run", 64'(bus.state), 64'd0);
    chk("lu_next_instr", 64'(bus.instr_id), 64'(NEXT));
    chk("lu_stall_cnt", 64'(bus.stall_cnt), PERF ? 64'd1 : 64'd0);

    // No false stall: Rd=31, RegWrite=0, valid_id=0
    tick(); bus.instr_if = RN31;
    tick(); bus.MemtoReg_ex = 1'b1; bus.RegWrite_ex = 1'b1; bus.Rd_ex = 5'd31;
    @(negedge clk);
    chk("nf_rd31_pc_write", 64'(bus.pc_write), 64'd1);
    chk("nf_rd31_bubble", 64'(bus.bubble_id), 64'd0);
    tick(); bus.RegWrite_ex = 1'b0; bus.Rd_ex = 5'd4;
    @(negedge clk);
    chk("nf_nowr_pc_write", 64'(bus.pc_write), 64'd1);
    tick(); bus.valid_if = 1'b0; bus.instr_if = ADD;
    tick(); bus.RegWrite_ex = 1'b1; bus.Rd_ex = 5'd3;
    @(negedge clk);
    chk("nf_inv_valid", 64'(bus.valid_id), 64'd0);
    chk("nf_inv_pc_write", 64'(bus.pc_write), 64'd1);
    chk("nf_inv_bubble", 64'(bus.bubble_id), 64'd0);

    // Store Rt hazard through ab_sel_id
    tick(); bus.RegWrite_ex = 1'b0; bus.valid_if = 1'b1; bus.instr_if = STUR; bus.ab_sel_id = 1'b1;
    tick(); bus.MemtoReg_ex = 1'b1; bus.RegWrite_ex = 1'b1; bus.Rd_ex = 5'd7;
    @(negedge clk);
    chk("st_pc_write", 64'(bus.pc_write), 64'd0);
    chk("st_bubble", 64'(bus.bubble_id), 64'd1);
    tick(); bus.RegWrite_ex = 1'b0;
    @(negedge clk);
    chk("st_state", 64'(bus.state), 64'd1);
    tick(); bus.ab_sel_id = 1'b0; bus.RegWrite_ex = 1'b1;
    @(negedge clk);
    chk("st_rm_state", 64'(bus.state), 64'd0);
    chk("st_rm_pc_write", 64'(bus.pc_write), 64'd1);
    chk("st_rm_bubble", 64'(bus.bubble_id), 64'd0);

    // Hazard and taken branch together
    tick(); bus.ab_sel_id = 1'b1; bus.BrTaken = 1'b1;
    @(negedge clk);
    chk("sim_pc_write", 64'(bus.pc_write), 64'd1);
    chk("sim_bubble", 64'(bus.bubble_id), 64'd0);
    tick(); bus.BrTaken = 1'b0; bus.MemtoReg_ex = 1'b0; bus.RegWrite_ex = 1'b0;
    @(negedge clk);
    chk("sim_valid", 64'(bus.valid_id), 64'd0);
    chk("sim_state", 64'(bus.state), 64'd2);
    chk("sim_instr", 64'(bus.instr_id), 64'(NOP));
    chk("sim_stall_cnt", 64'(bus.stall_cnt), PERF ? 64'd2 : 64'd0);
    chk("sim_flush_cnt", 64'(bus.flush_cnt), PERF ? 64'd1 : 64'd0);

    // 17 flushes from reset saturate the 4-bit counter
    tick(); reset = 1'b0;
    tick(); reset = 1'b1; bus.BrTaken = 1'b1;
    repeat (17) tick();
    @(negedge clk);
    chk("sat_flush_cnt", 64'(bus.flush_cnt), PERF ? 64'hF : 64'd0);
    chk("sat_state", 64'(bus.state), 64'd2);

    // Reset mid-FLUSH with branch still asserted aborts to RUN
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rstf_pc_write", 64'(bus.pc_write), 64'd1);
    chk("rstf_bubble", 64'(bus.bubble_id), 64'd0);
    tick(); reset = 1'b1; bus.BrTaken = 1'b0;
    @(negedge clk);
    chk("rstf_state", 64'(bus.state), 64'd0);
    chk("rstf_flush_cnt", 64'(bus.flush_cnt), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset           = ($urandom_range(0, 59) != 0);
      bus.instr_if    = rand_instr();
      bus.pc_if       = {$urandom, $urandom};
      bus.valid_if    = ($urandom_range(0, 4) != 0);
      bus.ab_sel_id   = 1'($urandom_range(0, 1));
      bus.MemtoReg_ex = ($urandom_range(0, 3) != 0);
      bus.RegWrite_ex = ($urandom_range(0, 3) != 0);
      bus.Rd_ex       = pick_reg();
      bus.BrTaken     = ($urandom_range(0, 7) == 0);
    end
    tick();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
